// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared March C- BIST types and per-element constant tables
package sram_bist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

  // Bit i of each table describes element Mi; the top two bits are unused encodings.
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] ELEM_RD_BG   = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_BG   = 8'b0000_1010;

  // Two-op elements read first then write; single-op elements are M0 (write) and M5 (read).
  function automatic logic op_is_read(input elem_e e, input logic phase);
    if (ELEM_TWO_OPS[e]) begin
      return !phase;
    end
    return e == M5;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - up/down address counter with load, step and last-address flag
module sram_bist_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    load_down,
  input  logic                    step,
  input  logic                    down,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic                    last
);

  localparam logic [P_ADDR_WIDTH-1:0] ONE = P_ADDR_WIDTH'(1);

  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_down ? '1 : '0;
    end else if (step) begin
      addr_d = down ? addr_q - ONE : addr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_1p_march_bist.sv
// rtl/sram_1p_march_bist.sv - March C- BIST controller for a single-port byte-mask SRAM BIST port
// The failure log (fail_addr/fail_elem/fail_syn) is built only when SRAM_BIST_FAIL_LOG_EN is defined.
module sram_1p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 9
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]              fail_elem,
  output logic [P_DATA_WIDTH-1:0] fail_syn,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  state_e                  state_q, state_d;
  elem_e                   elem_q, elem_d;
  logic                    phase_q, phase_d;
  logic                    done_q, done_d, fail_q, fail_d, busy_q, busy_d;
  logic                    men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [P_DATA_WIDTH-1:0] din_q, din_d, bm_q, bm_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [P_DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic                    ag_load, ag_load_down, ag_step, ag_last;
  logic                    start_run, miscmp, issue, rd;
  logic [P_ADDR_WIDTH-1:0] addr;

  sram_bist_addr_gen #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_addr_gen (
    .clk       (A_BIST_CLK),
    .rst       (A_BIST_RST),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (ELEM_DOWN[elem_q]),
    .addr      (addr),
    .last      (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    done_d       = done_q;
    fail_d       = fail_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    start_run    = 1'b0;
    miscmp       = cmp_vld_q && (A_DOUT != cmp_exp_q);
    if (miscmp) begin
      fail_d = 1'b1;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = ST_RUN;
          elem_d    = M0;
          phase_d   = 1'b0;
          ag_load   = 1'b1;
          done_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (ELEM_TWO_OPS[elem_q] && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!ag_last) begin
            ag_step = 1'b1;
          end else if (elem_q == M5) begin
            state_d = ST_DRAIN;
            ag_load = 1'b1;
          end else begin
            elem_d       = elem_e'(elem_q + 3'd1);
            ag_load      = 1'b1;
            ag_load_down = ELEM_DOWN[elem_d];
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus registers carry the op selected for the coming cycle.
    issue  = (state_d == ST_RUN);
    rd     = op_is_read(elem_d, phase_d);
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    men_d  = issue;
    wen_d  = issue && !rd;
    ren_d  = issue && rd;
    din_d  = (issue && !rd) ? {P_DATA_WIDTH{ELEM_WR_BG[elem_d]}} : '0;
    bm_d   = issue ? '1 : '0;

    // The op on the bus now is sampled by the macro at the next edge; its data returns one cycle later.
    cmp_vld_d = ren_q;
    cmp_exp_d = {P_DATA_WIDTH{ELEM_RD_BG[elem_q]}};
  end

  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      state_q   <= ST_IDLE;
      elem_q    <= M0;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      men_q     <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      din_q     <= '0;
      bm_q      <= '0;
      cmp_vld_q <= 1'b0;
      cmp_exp_q <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      men_q     <= men_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      din_q     <= din_d;
      bm_q      <= bm_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_exp_q <= cmp_exp_d;
    end
  end

`ifdef SRAM_BIST_FAIL_LOG_EN
  logic [P_ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d, log_addr_q, log_addr_d;
  logic [2:0]              cmp_elem_q, cmp_elem_d, log_elem_q, log_elem_d;
  logic [P_DATA_WIDTH-1:0] log_syn_q, log_syn_d;

  always_comb begin
    cmp_addr_d = addr;
    cmp_elem_d = elem_q;
    log_addr_d = log_addr_q;
    log_elem_d = log_elem_q;
    log_syn_d  = log_syn_q;
    if (start_run) begin
      log_addr_d = '0;
      log_elem_d = '0;
      log_syn_d  = '0;
    end else if (miscmp && !fail_q) begin
      log_addr_d = cmp_addr_q;
      log_elem_d = cmp_elem_q;
      log_syn_d  = cmp_exp_q ^ A_DOUT;
    end
  end

  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
      log_addr_q <= '0;
      log_elem_q <= '0;
      log_syn_q  <= '0;
    end else begin
      cmp_addr_q <= cmp_addr_d;
      cmp_elem_q <= cmp_elem_d;
      log_addr_q <= log_addr_d;
      log_elem_q <= log_elem_d;
      log_syn_q  <= log_syn_d;
    end
  end

  assign fail_addr = log_addr_q;
  assign fail_elem = log_elem_q;
  assign fail_syn  = log_syn_q;
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_syn  = '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign A_BIST_EN   = busy_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = addr;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;

endmodule
